// File: rtl/decode_ctrl_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | decode_ctrl_pipe: registered, handshaked R/I-type ALU control decoder       |
// | Rev 1.0 - initial release                                                   |
// +-----------------------------------------------------------------------------+
module decode_ctrl_pipe #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 3,
  parameter int LEGACY_MUL  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_control,
  output logic            regwrite,
  output logic            use_imm,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic            illegal
);

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_MUL  = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;

  // Counter only ever holds MUL_LATENCY-2 down to 0.
  localparam int CNT_W    = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY - 1) : 1;
  localparam int CNT_INIT = (MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FULL  = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]       alu_control_q, alu_control_d;
  logic             regwrite_q, regwrite_d;
  logic             use_imm_q, use_imm_d;
  logic [XLEN-1:0]  imm_q, imm_d;
  logic [4:0]       rd_q, rd_d;
  logic [4:0]       rs1_q, rs1_d;
  logic [4:0]       rs2_q, rs2_d;
  logic             illegal_q, illegal_d;

  logic [3:0]       dec_alu;
  logic             dec_regwrite;
  logic             dec_use_imm;
  logic [XLEN-1:0]  dec_imm;
  logic [4:0]       dec_rs2;
  logic             dec_bad;

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             out_is_mul;
  logic             accept;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    dec_alu      = ALU_AND;
    dec_regwrite = 1'b0;
    dec_use_imm  = 1'b0;
    dec_imm      = '0;
    dec_rs2      = instr[24:20];
    dec_bad      = 1'b0;
    case (opcode)
      OP_R: begin
        dec_regwrite = 1'b1;
        case ({funct3, funct7})
          {3'd0, 7'h00}: dec_alu = ALU_ADD;
          {3'd0, 7'h20}: dec_alu = ALU_SUB;
          {3'd0, 7'h01}: dec_alu = ALU_MUL;
          {3'd1, 7'h00}: dec_alu = ALU_SLL;
          {3'd2, 7'h00}: dec_alu = (LEGACY_MUL != 0) ? ALU_MUL : ALU_SLT;
          {3'd3, 7'h00}: dec_alu = ALU_SLTU;
          {3'd4, 7'h00}: dec_alu = ALU_XOR;
          {3'd5, 7'h00}: dec_alu = ALU_SRL;
          {3'd5, 7'h20}: dec_alu = ALU_SRA;
          {3'd6, 7'h00}: dec_alu = ALU_OR;
          {3'd7, 7'h00}: dec_alu = ALU_AND;
          default:       dec_bad = 1'b1;
        endcase
      end
      OP_I: begin
        dec_regwrite = 1'b1;
        dec_use_imm  = 1'b1;
        dec_imm      = {{(XLEN-12){instr[31]}}, instr[31:20]};
        dec_rs2      = 5'd0;
        case (funct3)
          3'd0: dec_alu = ALU_ADD;
          3'd2: dec_alu = ALU_SLT;
          3'd3: dec_alu = ALU_SLTU;
          3'd4: dec_alu = ALU_XOR;
          3'd6: dec_alu = ALU_OR;
          3'd7: dec_alu = ALU_AND;
          3'd1: begin
            if (funct7 == 7'h00) dec_alu = ALU_SLL;
            else                 dec_bad = 1'b1;
          end
          default: begin
            if (funct7 == 7'h00)      dec_alu = ALU_SRL;
            else if (funct7 == 7'h20) dec_alu = ALU_SRA;
            else                      dec_bad = 1'b1;
          end
        endcase
      end
      default: dec_bad = 1'b1;
    endcase
    // An illegal word carries no operation, only the flag.
    if (dec_bad) begin
      dec_alu      = ALU_AND;
      dec_regwrite = 1'b0;
      dec_use_imm  = 1'b0;
      dec_imm      = '0;
    end
  end

  assign out_is_mul = (alu_control_q == ALU_MUL);
  assign in_ready   = (state_q == S_IDLE) ||
                      ((state_q == S_FULL) && out_ready && !out_is_mul);
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_q == S_FULL);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_FULL;
      end
      S_FULL: begin
        if (out_ready) begin
          if (out_is_mul) begin
            if (MUL_LATENCY == 1) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_STALL;
              cnt_d   = CNT_W'(CNT_INIT);
            end
          end else if (!accept) begin
            state_d = S_IDLE;
          end
        end
      end
      S_STALL: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    alu_control_d = alu_control_q;
    regwrite_d    = regwrite_q;
    use_imm_d     = use_imm_q;
    imm_d         = imm_q;
    rd_d          = rd_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    illegal_d     = illegal_q;
    if (accept) begin
      alu_control_d = dec_alu;
      regwrite_d    = dec_regwrite;
      use_imm_d     = dec_use_imm;
      imm_d         = dec_imm;
      rd_d          = instr[11:7];
      rs1_d         = instr[19:15];
      rs2_d         = dec_rs2;
      illegal_d     = dec_bad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      alu_control_q <= '0;
      regwrite_q    <= 1'b0;
      use_imm_q     <= 1'b0;
      imm_q         <= '0;
      rd_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      alu_control_q <= alu_control_d;
      regwrite_q    <= regwrite_d;
      use_imm_q     <= use_imm_d;
      imm_q         <= imm_d;
      rd_q          <= rd_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      illegal_q     <= illegal_d;
    end
  end

  assign alu_control = alu_control_q;
  assign regwrite    = regwrite_q;
  assign use_imm     = use_imm_q;
  assign imm         = imm_q;
  assign rd          = rd_q;
  assign rs1         = rs1_q;
  assign rs2         = rs2_q;
  assign illegal     = illegal_q;

endmodule
`default_nettype wire
